hp_int_to_fp16: RTL and testbench
=================================

// Module: hp_int_to_fp16
// PURPOSE
//  Sequential converter: signed two's-complement integer -> IEEE-754 half precision (1/5/10).
//  Produces operands for the half-precision adder datapath (writer side of the fp16 format).
//  Iterative normaliser: one left shift per clock. valid/ready handshake on input and output.
// PARAMETERS
//  INT_W   16   integer input width; legal range 16..32 (>=17 makes fp16 overflow possible)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      int_in valid
//  in_ready   out  1      converter idle, accepts int_in
//  int_in     in   INT_W  signed integer operand
//  out_valid  out  1      hp_out/ex_flag valid
//  out_ready  in   1      consumer takes result
//  hp_out     out  16     {sign, exp[4:0], mant[9:0]}
//  ex_flag    out  2      {inexact, overflow}
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; in_ready=1, out_valid=0, hp_out=16'h0000, ex_flag=2'b00;
//   in-flight conversion discarded, no output produced for it.
//  FSM states: IDLE, ABS, NORM, ROUND, DONE.
//  IDLE: in_ready=1; accept edge = in_valid&&in_ready; latch int_in, sign=int_in[INT_W-1]; -> ABS.
//   in_valid outside IDLE ignored; int_in sampled only on accept edge.
//  ABS: mag = sign ? -int_in : int_in, held in INT_W-bit unsigned reg (-2^(INT_W-1) -> 2^(INT_W-1)).
//   lz counter cleared. mag==0 -> load hp_out={1'b0,15'b0}, ex_flag=00, -> DONE; else -> NORM.
//  NORM: per edge: mag[INT_W-1]==0 -> mag<<=1, lz++; else -> ROUND. Occupies lz+1 cycles.
//  ROUND: mant=mag[INT_W-2 -: 10]; guard=mag[INT_W-12]; sticky=|mag[INT_W-13:0];
//   biased exp = 15 + (INT_W-1) - lz (6-bit arithmetic, no wrap).
//   round-up decision per CONFIGURATION; mant+1 carry out -> mant=0, exp+1.
//   exp>=31 -> hp_out={sign,5'h1F,10'h000}, ex_flag[0]=1; else hp_out={sign,exp[4:0],mant}.
//   ex_flag[1]=guard|sticky (inexact). -> DONE.
//  DONE: out_valid=1, in_ready=0; hp_out/ex_flag stable while out_valid&&!out_ready.
//   out_ready high -> IDLE next edge (out_valid=0, in_ready=1); no accept in same edge.
//  Latency (accept edge -> out_valid high): zero input 2 edges; nonzero lz+4 edges
//   (lz = leading zeros of |int_in| in INT_W bits). Throughput: one conversion in flight.
//  Zero result never negative (-0 not produced). No underflow/subnormal possible.
//  hp_out/ex_flag retain last result after DONE until overwritten by next ROUND/ABS-zero.
// CONFIGURATION
//  HP_I2F_RNE_EN defined: round-to-nearest-even: up = guard & (sticky | mant[0]).
//  HP_I2F_RNE_EN undefined: round-half-away (matches adder rounder): up = guard.
//  All other behaviour identical in both builds.
// TESTING
//  1 (INT_W=16) -> hp_out=16'h3C00, ex_flag=00, out_valid 19 edges after accept (lz=15).
//  -2 -> 16'hC000, ex_flag=00; 0 -> 16'h0000, ex_flag=00, out_valid 2 edges after accept.
//  -32768 -> 16'hF800, ex_flag=00, lz=0, latency 4 edges.
//  2049 -> ex_flag=2'b10; hp_out=16'h6801 without macro, 16'h6800 with HP_I2F_RNE_EN.
//  INT_W=32, 65520 -> 16'h7C00, ex_flag=2'b11 (both builds); 65504 -> 16'h7BFF, ex_flag=00.
//  Backpressure: hold out_ready=0 10 cycles in DONE -> outputs stable, in_ready=0, new in_valid
//   ignored; rst pulse mid-NORM -> IDLE immediately, out_valid stays 0, next conversion correct.

Source files
------------

// File: rtl/hp_int_to_fp16.sv
// Iterative signed-integer to IEEE-754 half-precision converter, normalising one bit per clock.
// Build option: define HP_I2F_RNE_EN for round-to-nearest-even; default rounds half away from zero.
module hp_int_to_fp16 #(
  parameter int INT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] int_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      hp_out,
  output logic [1:0]       ex_flag,
  output logic [2:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE and the result is held
  // unchanged until out_ready is seen, after which the converter returns to IDLE.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ABS   = 3'd1,
    S_NORM  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [5:0] EXP_TOP = 6'(15 + INT_W - 1);

  state_t           state_q;
  logic [INT_W-1:0] mag_q;
  logic             sign_q;
  logic [5:0]       lz_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [15:0]      hp_q;
  logic [1:0]       ex_q;

  logic [INT_W-1:0] mag_abs_d;
  logic [9:0]       mant_raw;
  logic             guard;
  logic             sticky;
  logic             round_up;
  logic [10:0]      mant_sum;
  logic [5:0]       exp_raw;
  logic [5:0]       exp_rnd;
  logic             ovf;
  logic [15:0]      hp_d;
  logic [1:0]       ex_d;

  always_comb begin
    mag_abs_d = sign_q ? ({INT_W{1'b0}} - mag_q) : mag_q;
    mant_raw  = mag_q[INT_W-2 -: 10];
    guard     = mag_q[INT_W-12];
    sticky    = |mag_q[INT_W-13:0];
`ifdef HP_I2F_RNE_EN
    round_up  = guard & (sticky | mant_raw[0]);
`else
    round_up  = guard;
`endif
    mant_sum  = {1'b0, mant_raw} + {10'd0, round_up};
    exp_raw   = EXP_TOP - lz_q;
    // A mantissa carry leaves mant_sum[9:0] at zero and bumps the exponent.
    exp_rnd   = exp_raw + {5'd0, mant_sum[10]};
    ovf       = (exp_rnd >= 6'd31);
    hp_d      = ovf ? {sign_q, 5'h1F, 10'h000} : {sign_q, exp_rnd[4:0], mant_sum[9:0]};
    ex_d      = {guard | sticky, ovf};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mag_q       <= '0;
      sign_q      <= 1'b0;
      lz_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      hp_q        <= 16'h0000;
      ex_q        <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mag_q      <= int_in;
            sign_q     <= int_in[INT_W-1];
            in_ready_q <= 1'b0;
            state_q    <= S_ABS;
          end
        end
        S_ABS: begin
          mag_q <= mag_abs_d;
          lz_q  <= '0;
          if (mag_abs_d == '0) begin
            hp_q        <= 16'h0000;
            ex_q        <= 2'b00;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            state_q <= S_NORM;
          end
        end
        S_NORM: begin
          if (!mag_q[INT_W-1]) begin
            mag_q <= mag_q << 1;
            lz_q  <= lz_q + 6'd1;
          end else begin
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          hp_q        <= hp_d;
          ex_q        <= ex_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign hp_out    = hp_q;
  assign ex_flag   = ex_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hp_int_to_fp16.sv
// Bench for hp_int_to_fp16: INT_W=16 and INT_W=32 instances against an arithmetic reference model.
`timescale 1ns/1ps
module tb_hp_int_to_fp16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        use32;
  logic        iv;
  logic        ordy;
  logic [31:0] din;

  logic        rdy16, ov16, rdy32, ov32;
  logic [15:0] hp16, hp32;
  logic [1:0]  ex16, ex32;
  logic [2:0]  st16, st32;
  logic        iv16, iv32, ordy16, ordy32;

  assign iv16   = iv & ~use32;
  assign iv32   = iv & use32;
  assign ordy16 = ordy & ~use32;
  assign ordy32 = ordy & use32;

  hp_int_to_fp16 #(.INT_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16), .int_in(din[15:0]),
    .out_valid(ov16), .out_ready(ordy16), .hp_out(hp16), .ex_flag(ex16), .dbg_state(st16)
  );

  hp_int_to_fp16 #(.INT_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(rdy32), .int_in(din),
    .out_valid(ov32), .out_ready(ordy32), .hp_out(hp32), .ex_flag(ex32), .dbg_state(st32)
  );

  logic        o_ready, o_valid;
  logic [15:0] o_hp;
  logic [1:0]  o_ex;
  assign o_ready = use32 ? rdy32 : rdy16;
  assign o_valid = use32 ? ov32  : ov16;
  assign o_hp    = use32 ? hp32  : hp16;
  assign o_ex    = use32 ? ex32  : ex16;

  // scoreboard
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [17:0] exp_q[$];
  logic [15:0] last_hp;
  logic [1:0]  last_ex;
  int          last_lat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: exact integer magnitude, rounded by comparing the discarded remainder to one half.
  function automatic void ref_conv(input longint v, input int w, output logic [15:0] hp,
                                   output logic [1:0] ex, output int lat);
    longint mag, q, rem, half;
    int     p, e, sh;
    logic   s, up, inex;
    s = (v < 0);
    mag = s ? -v : v;
    if (mag == 0) begin
      hp = 16'h0000; ex = 2'b00; lat = 2;
      return;
    end
    p = 0;
    for (int i = 0; i < w; i++) if (mag >= (longint'(1) << i)) p = i;
    lat = (w - 1 - p) + 4;
    e = 15 + p;
    if (p > 10) begin
      sh   = p - 10;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      inex = (rem != 0);
`ifdef HP_I2F_RNE_EN
      up = (rem > half) || ((rem == half) && (q % 2 == 1));
`else
      up = (rem >= half);
`endif
    end else begin
      q = mag << (10 - p);
      inex = 1'b0;
      up = 1'b0;
    end
    if (up) q = q + 1;
    if (q == 2048) begin
      q = 1024;
      e = e + 1;
    end
    if (e >= 31) begin
      hp = {s, 5'h1F, 10'h000};
      ex = {inex, 1'b1};
    end else begin
      hp = {s, 5'(e), 10'(q)};
      ex = {inex, 1'b0};
    end
  endfunction

  // driver: one conversion, with `hold` cycles of backpressure while DONE
  task automatic run_conv(input logic sel, input logic [31:0] pat, input int hold);
    longint      v;
    logic [15:0] ehp;
    logic [1:0]  eex;
    int          elat, edges, t;
    logic [17:0] expv;
    v = sel ? longint'($signed(pat)) : longint'($signed(pat[15:0]));
    ref_conv(v, sel ? 32 : 16, ehp, eex, elat);
    @(negedge clk);
    use32 = sel;
    din = pat;
    t = 0;
    while (!o_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("in_ready_before_accept", {31'd0, o_ready}, 32'd1);
    iv = 1'b1;
    exp_q.push_back({eex, ehp});
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    iv = 1'b0;
    din = $urandom;
    while (!o_valid && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    last_lat = edges;
    check_eq("latency", edges, elat);
    check_eq("out_valid", {31'd0, o_valid}, 32'd1);
    check_eq("in_ready_busy", {31'd0, o_ready}, 32'd0);
    expv = exp_q[0];
    for (int i = 0; i < hold; i++) begin
      iv = 1'b1;
      din = $urandom;
      @(negedge clk);
      check_eq("hold_valid", {31'd0, o_valid}, 32'd1);
      check_eq("hold_ready", {31'd0, o_ready}, 32'd0);
      check_eq("hold_hp", {16'd0, o_hp}, {16'd0, expv[15:0]});
    end
    iv = 1'b0;
    expv = exp_q.pop_front();
    last_hp = o_hp;
    last_ex = o_ex;
    check_eq("hp_out", {16'd0, o_hp}, {16'd0, expv[15:0]});
    check_eq("ex_flag", {30'd0, o_ex}, {30'd0, expv[17:16]});
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    check_eq("post_valid", {31'd0, o_valid}, 32'd0);
    check_eq("post_ready", {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] pat;
    rst = 1'b1; use32 = 1'b0; iv = 1'b0; ordy = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready16", {31'd0, rdy16}, 32'd1);
    check_eq("rst_valid16", {31'd0, ov16}, 32'd0);
    check_eq("rst_hp16", {16'd0, hp16}, 32'd0);
    check_eq("rst_ex32", {30'd0, ex32}, 32'd0);
    check_eq("rst_ready32", {31'd0, rdy32}, 32'd1);
    rst = 1'b0;

    // directed vectors
    run_conv(1'b0, 32'h0000_0001, 0);
    check_eq("one_hp", {16'd0, last_hp}, 32'h3C00);
    check_eq("one_ex", {30'd0, last_ex}, 32'd0);
    check_eq("one_lat", last_lat, 32'd19);
    run_conv(1'b0, 32'h0000_FFFE, 0);
    check_eq("m2_hp", {16'd0, last_hp}, 32'hC000);
    run_conv(1'b0, 32'h0000_0000, 1);
    check_eq("zero_hp", {16'd0, last_hp}, 32'h0000);
    check_eq("zero_lat", last_lat, 32'd2);
    run_conv(1'b0, 32'h0000_8000, 0);
    check_eq("min_hp", {16'd0, last_hp}, 32'hF800);
    check_eq("min_lat", last_lat, 32'd4);
    run_conv(1'b0, 32'd2049, 10);
    check_eq("2049_ex", {30'd0, last_ex}, 32'd2);
`ifdef HP_I2F_RNE_EN
    check_eq("2049_hp", {16'd0, last_hp}, 32'h6800);
`else
    check_eq("2049_hp", {16'd0, last_hp}, 32'h6801);
`endif
    run_conv(1'b0, 32'h0000_7FFF, 0);
    run_conv(1'b0, 32'h0000_FFFF, 2);
    run_conv(1'b1, 32'd65520, 0);
    check_eq("65520_hp", {16'd0, last_hp}, 32'h7C00);
    check_eq("65520_ex", {30'd0, last_ex}, 32'd3);
    run_conv(1'b1, 32'd65504, 0);
    check_eq("65504_hp", {16'd0, last_hp}, 32'h7BFF);
    check_eq("65504_ex", {30'd0, last_ex}, 32'd0);
    run_conv(1'b1, 32'h8000_0000, 1);
    run_conv(1'b1, 32'h7FFF_FFFF, 0);
    run_conv(1'b1, 32'hFFFF_F7FF, 0);
    run_conv(1'b1, 32'h0000_0000, 0);

    // reset mid-normalisation
    @(negedge clk);
    use32 = 1'b0; din = 32'd1; iv = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_valid", {31'd0, ov16}, 32'd0);
    check_eq("midrst_ready", {31'd0, rdy16}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("midrst_no_out", {31'd0, ov16}, 32'd0);
    check_eq("midrst_hp", {16'd0, hp16}, 32'd0);
    run_conv(1'b0, 32'h0000_0003, 0);
    check_eq("after_rst_hp", {16'd0, last_hp}, 32'h4200);

    // randomized
    for (int k = 0; k < 40; k++) begin
      pat = $urandom >> $urandom_range(16, 31);
      if ($urandom_range(0, 1) == 1) pat = -pat;
      run_conv(1'b0, pat, $urandom_range(0, 3));
    end
    for (int k = 0; k < 40; k++) begin
      pat = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) pat = -pat;
      run_conv(1'b1, pat, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
